// File: rtl/vga_scanout_if.sv
// Frame-buffer read port shared between the scan-out engine and the SRAM mux.
interface vga_scanout_if;
  logic [15:0] I_SRAM_DATA;
  logic [17:0] O_SR_ADDR;
  logic        O_SR_READ;
  logic        O_VIDEO_ON;

  modport master (
    input  I_SRAM_DATA,
    output O_SR_ADDR,
    output O_SR_READ,
    output O_VIDEO_ON
  );

  modport slave (
    output I_SRAM_DATA,
    input  O_SR_ADDR,
    input  O_SR_READ,
    input  O_VIDEO_ON
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA timing generator and frame-buffer reader: counters -> fetch stage -> output stage,
// all advancing only on pixel ticks.
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned FB_ROWS  = 400
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_PIX_EN,
  vga_scanout_if.master sram,
  output logic [3:0]    O_VGA_R,
  output logic [3:0]    O_VGA_G,
  output logic [3:0]    O_VGA_B,
  output logic          O_HS,
  output logic          O_VS,
  output logic          O_DE,
  output logic          O_FRAME_START
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_FB   = VW'(FB_ROWS);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [17:0]   addr_cnt;

  logic h_vis, fetch, h_wrap, frame_end;
  logic fetch_d, de_d, hs_d, vs_d, fs_d;

  // Colour lives in [11:0]; the top nibble of the SRAM word has no meaning here.
  logic unused_sram_hi;
  assign unused_sram_hi = ^sram.I_SRAM_DATA[15:12];

  always_comb begin
    h_vis     = hcnt < H_VIS;
    fetch     = h_vis && (vcnt < V_FB);
    h_wrap    = hcnt == H_LAST;
    frame_end = h_wrap && (vcnt == V_LAST);
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (I_PIX_EN) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // Fetch stage. The running address counter replaces row*H_ACTIVE+col; the
  // frame-end clear never collides with an increment because fetch is low there.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      addr_cnt        <= '0;
      sram.O_SR_ADDR  <= '0;
      sram.O_SR_READ  <= 1'b0;
      sram.O_VIDEO_ON <= 1'b0;
      fetch_d         <= 1'b0;
      de_d            <= 1'b0;
      hs_d            <= 1'b0;
      vs_d            <= 1'b0;
      fs_d            <= 1'b0;
    end else if (I_PIX_EN) begin
      sram.O_SR_READ  <= fetch;
      sram.O_VIDEO_ON <= fetch;
      if (fetch) begin
        sram.O_SR_ADDR <= addr_cnt;
      end
      if (frame_end) begin
        addr_cnt <= '0;
      end else if (fetch) begin
        addr_cnt <= addr_cnt + 18'd1;
      end
      fetch_d <= fetch;
      de_d    <= h_vis && (vcnt < V_VIS);
      hs_d    <= (hcnt >= HS_BEG) && (hcnt < HS_END);
      vs_d    <= (vcnt >= VS_BEG) && (vcnt < VS_END);
      fs_d    <= (hcnt == '0) && (vcnt == '0);
    end
  end

  // Output stage: SRAM data has settled since the previous tick's address.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_VGA_R       <= '0;
      O_VGA_G       <= '0;
      O_VGA_B       <= '0;
      O_DE          <= 1'b0;
      O_HS          <= 1'b1;
      O_VS          <= 1'b1;
      O_FRAME_START <= 1'b0;
    end else if (I_PIX_EN) begin
      if (fetch_d) begin
        O_VGA_R <= sram.I_SRAM_DATA[11:8];
        O_VGA_G <= sram.I_SRAM_DATA[7:4];
        O_VGA_B <= sram.I_SRAM_DATA[3:0];
      end else begin
        O_VGA_R <= '0;
        O_VGA_G <= '0;
        O_VGA_B <= '0;
      end
      O_DE          <= de_d;
      O_HS          <= ~hs_d;
      O_VS          <= ~vs_d;
      O_FRAME_START <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a position-level model queues expected outputs per tick,
// a monitor pops and compares them every cycle, including stalls and reset.
module tb_vga_scanout;

  localparam int H_ACT = 640, H_FP = 4, H_SY = 8, H_BP = 4;
  localparam int V_ACT = 6, V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int FB_R  = 4;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  typedef struct packed {
    logic [17:0] addr;
    logic        rd;
    logic        von;
  } fexp_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        chk505;
  } pexp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hs, vs, de, fs;

  vga_scanout_if bus ();

  vga_scanout #(
    .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
    .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
    .FB_ROWS  (FB_R)
  ) dut (
    .I_CLK         (clk),
    .I_RST_N       (rst_n),
    .I_PIX_EN      (pix_en),
    .sram          (bus.master),
    .O_VGA_R       (vga_r),
    .O_VGA_G       (vga_g),
    .O_VGA_B       (vga_b),
    .O_HS          (hs),
    .O_VS          (vs),
    .O_DE          (de),
    .O_FRAME_START (fs)
  );

  always #5 clk = ~clk;

  int          mode;
  logic [15:0] mask;

  function automatic logic [15:0] data_of(int m, int a);
    logic [31:0] av;
    av = a;
    case (m)
      0:       return av[15:0];
      1:       return 16'hFFFF;
      default: return av[15:0] ^ mask;
    endcase
  endfunction

  // SRAM: data for the presented address is valid one clock later.
  always @(posedge clk) bus.I_SRAM_DATA <= data_of(mode, int'(bus.O_SR_ADDR));

  fexp_t qf[$];
  pexp_t qp[$];
  int n_cmp = 0, n_bad = 0;

  int mh, mv, mlast;
  int count_left = 0;
  int cnt_von = 0, cnt_hs = 0, cnt_vs = 0, cnt_de = 0, cnt_fs = 0, max_addr = -1;
  int n505 = 0;

  localparam pexp_t PIX_RST = '{rgb: 12'h0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, chk505: 1'b0};

  task automatic reset_model();
    mh = 0; mv = 0; mlast = 0;
    qf.delete();
    qp.delete();
    qp.push_back(PIX_RST);
  endtask

  task automatic tick();
    fexp_t       e;
    pexp_t       p;
    logic        f;
    int          a;
    logic [15:0] d;
    @(negedge clk);
    f = (mh < H_ACT) && (mv < FB_R);
    a = mv * H_ACT + mh;
    if (f) mlast = a;
    e.addr = 18'(mlast);
    e.rd   = f;
    e.von  = f;
    d = data_of(mode, a);
    p.rgb    = f ? d[11:0] : 12'h0;
    p.de     = (mh < H_ACT) && (mv < V_ACT);
    p.hs     = !((mh >= H_ACT + H_FP) && (mh < H_ACT + H_FP + H_SY));
    p.vs     = !((mv >= V_ACT + V_FP) && (mv < V_ACT + V_FP + V_SY));
    p.fs     = (mh == 0) && (mv == 0);
    p.chk505 = (mode == 0) && (mh == 5) && (mv == 2);
    qf.push_back(e);
    qp.push_back(p);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    if ($urandom_range(0, 7) == 0) @(negedge clk);
    mh++;
    if (mh == H_TOT) begin
      mh = 0;
      mv = (mv == V_TOT - 1) ? 0 : mv + 1;
    end
  endtask

  task automatic run_ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_int(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  logic tick_q = 1'b0;
  always @(posedge clk) tick_q <= rst_n && pix_en;

  // Monitor: one popped expectation per tick, compared on every cycle so frozen
  // outputs during stalls are covered too.
  initial begin : monitor
    fexp_t       cf;
    pexp_t       cp;
    logic [35:0] act, exp;
    cf = '0;
    cp = PIX_RST;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cf = '0;
        cp = PIX_RST;
      end else if (tick_q) begin
        if (qf.size() == 0 || qp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL underflow: tick with fetch queue %0d / pixel queue %0d entries", qf.size(), qp.size());
        end else begin
          cf = qf.pop_front();
          cp = qp.pop_front();
          if (cp.chk505) begin
            n505++;
            n_cmp++;
            if ({vga_r, vga_g, vga_b} !== 12'h505) begin
              n_bad++;
              $display("FAIL pix_5_2: rgb=%h expected 505", {vga_r, vga_g, vga_b});
            end
          end
          if (count_left > 0) begin
            count_left--;
            cnt_von += int'(bus.O_VIDEO_ON);
            cnt_hs  += int'(!hs);
            cnt_vs  += int'(!vs);
            cnt_de  += int'(de);
            cnt_fs  += int'(fs);
            if (bus.O_VIDEO_ON && int'(bus.O_SR_ADDR) > max_addr) max_addr = int'(bus.O_SR_ADDR);
          end
        end
      end
      act = {bus.O_SR_ADDR, bus.O_SR_READ, bus.O_VIDEO_ON, vga_r, vga_g, vga_b, de, hs, vs, fs};
      exp = {cf.addr, cf.rd, cf.von, cp.rgb, cp.de, cp.hs, cp.vs, cp.fs};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL outputs @%0t: got addr=%0d rd=%b von=%b rgb=%h de=%b hs=%b vs=%b fs=%b, expected addr=%0d rd=%b von=%b rgb=%h de=%b hs=%b vs=%b fs=%b",
                 $time, act[35:18], act[17], act[16], act[15:4], act[3], act[2], act[1], act[0],
                 exp[35:18], exp[17], exp[16], exp[15:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  end

  initial begin : stimulus
    rst_n  = 1'b0;
    pix_en = 1'b0;
    mode   = 0;
    mask   = 16'h0;
    reset_model();
    repeat (6) @(negedge clk) pix_en = ~pix_en;
    pix_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    reset_model();

    // Part-way into line 1, then reset mid-line with ticks still toggling.
    run_ticks(700);
    #2 rst_n = 1'b0;
    repeat (6) @(negedge clk) pix_en = ~pix_en;
    pix_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    reset_model();

    // Address-pattern frame with a 50-cycle stall in the middle of a visible line.
    run_ticks(1000);
    repeat (50) @(negedge clk);
    run_ticks(FRAME - 1000);

    // Two accounted frames: random-masked data, then all-ones data.
    mode = 2;
    mask = 16'($urandom);
    count_left = 2 * FRAME;
    run_ticks(FRAME);
    mode = 1;
    run_ticks(FRAME);

    repeat (3) @(negedge clk);
    #2;
    check_int("fetch_queue_drained", qf.size(), 0);
    check_int("pixel_queue_pending", qp.size(), 1);
    check_int("window_ticks_left", count_left, 0);
    check_int("video_on_ticks", cnt_von, 2 * FB_R * H_ACT);
    check_int("hs_low_ticks", cnt_hs, 2 * V_TOT * H_SY);
    check_int("vs_low_ticks", cnt_vs, 2 * V_SY * H_TOT);
    check_int("de_ticks", cnt_de, 2 * H_ACT * V_ACT);
    check_int("frame_starts", cnt_fs, 2);
    check_int("last_read_addr", max_addr, FB_R * H_ACT - 1);
    check_int("pix_5_2_seen", n505, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
